// File: rtl/fake_board_io_if.sv
// Pin bundle between the host-driven simulated board and the board I/O glue.
// The host side drives buttons/mode; the glue side drives debounced state, edges, LEDs and tick.
interface fake_board_io_if #(
  parameter int NUM_CH = 8
);
  logic [NUM_CH-1:0] buttons;
  logic [1:0]        mode;
  logic [NUM_CH-1:0] btn_state;
  logic [NUM_CH-1:0] btn_rise;
  logic [NUM_CH-1:0] btn_fall;
  logic [NUM_CH-1:0] leds;
  logic              tick;

  modport master (
    output buttons, mode,
    input  btn_state, btn_rise, btn_fall, leds, tick
  );

  modport slave (
    input  buttons, mode,
    output btn_state, btn_rise, btn_fall, leds, tick
  );
endinterface

// File: rtl/fake_board_io.sv
// Simulated board I/O glue: synchronises and debounces button channels, emits edge pulses,
// and drives the LEDs from a selectable pattern generator clocked by a blink divider.
module fake_board_io #(
  parameter int NUM_CH          = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_DIV       = 16
) (
  input  logic            clk,
  input  logic            rst,
  fake_board_io_if.slave  bus
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam int            BW        = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [CW-1:0]     cnt [NUM_CH];
  logic [NUM_CH-1:0] btn_state;
  logic [NUM_CH-1:0] btn_rise;
  logic [NUM_CH-1:0] btn_fall;
  logic [BW-1:0]     blink_cnt;
  logic              blink;
  logic              tick;
  logic [NUM_CH-1:0] pat;
  logic [1:0]        prev_mode;
  logic [NUM_CH-1:0] leds;

  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] chain;
  logic [NUM_CH-1:0] pat_next;
  logic [NUM_CH-1:0] led_next;

  // A channel flips once its differing level has persisted for the full debounce window.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i] = (sync2[i] != btn_state[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_comb begin
    logic acc;
    chain    = '0;
    acc      = blink;
    chain[0] = acc;
    for (int i = 1; i < NUM_CH; i++) begin
      acc      = acc ^ btn_state[i];
      chain[i] = acc;
    end
  end

  // On a mode switch the LEDs freeze for one cycle and seed pat, so no glitch is shown.
  always_comb begin
    pat_next = pat;
    led_next = leds;
    if (bus.mode != prev_mode) begin
      pat_next = leds;
      led_next = leds;
    end else begin
      case (bus.mode)
        2'd0: led_next = chain;
        2'd1: led_next = btn_state;
        2'd2: begin
          pat_next = pat ^ btn_rise;
          led_next = pat_next;
        end
        default: begin
          pat_next = (tick ? {pat[NUM_CH-2:0], pat[NUM_CH-1]} : pat) | btn_rise;
          led_next = pat_next;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      btn_state <= '0;
      btn_rise  <= '0;
      btn_fall  <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      tick      <= 1'b0;
      pat       <= '0;
      prev_mode <= 2'd0;
      leds      <= '0;
    end else begin
      sync1 <= bus.buttons;
      sync2 <= sync1;
      for (int i = 0; i < NUM_CH; i++) begin
        if ((sync2[i] == btn_state[i]) || accept[i]) cnt[i] <= '0;
        else                                          cnt[i] <= cnt[i] + 1'b1;
      end
      btn_state <= btn_state ^ accept;
      btn_rise  <= accept & sync2;
      btn_fall  <= accept & ~sync2;
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink     <= ~blink;
        tick      <= 1'b1;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
        tick      <= 1'b0;
      end
      pat       <= pat_next;
      leds      <= led_next;
      prev_mode <= bus.mode;
    end
  end

  assign bus.btn_state = btn_state;
  assign bus.btn_rise  = btn_rise;
  assign bus.btn_fall  = btn_fall;
  assign bus.leds      = leds;
  assign bus.tick      = tick;

endmodule

// File: tb/tb_fake_board_io.sv
// Scoreboard bench for fake_board_io: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fake_board_io;

  typedef enum int {SIG_STATE, SIG_RISE, SIG_FALL, SIG_LEDS, SIG_TICK} sig_e;
  typedef struct {
    int         cyc;
    sig_e       sig;
    logic [7:0] val;
    string      name;
  } sb_entry_t;

  logic      clk = 1'b0;
  logic      rst;
  int        cyc = 0;
  int        compared = 0;
  int        mismatched = 0;
  sb_entry_t sb[$];
  sb_entry_t mon_e;

  fake_board_io_if #(.NUM_CH(8)) bus();

  fake_board_io #(
    .NUM_CH(8),
    .DEBOUNCE_CYCLES(4),
    .BLINK_DIV(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic [7:0] b, input logic [1:0] m);
    bus.buttons = b;
    bus.mode    = m;
  endtask

  task automatic expect_at(input int c, input sig_e s, input logic [7:0] v, input string name);
    sb_entry_t e;
    e.cyc  = c;
    e.sig  = s;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic checkOutput(input sb_entry_t e);
    logic [7:0] act;
    case (e.sig)
      SIG_STATE: act = bus.btn_state;
      SIG_RISE:  act = bus.btn_rise;
      SIG_FALL:  act = bus.btn_fall;
      SIG_LEDS:  act = bus.leds;
      default:   act = {7'b0, bus.tick};
    endcase
    compared++;
    if (act !== e.val) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d (now %0d): actual %h required %h",
               e.name, e.cyc, cyc, act, e.val);
    end
  endtask

  // Entries are queued in cycle order; everything due at or before this edge is checked now.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(8'h00, 2'd0);

    wait_to(2);
    expect_at(3, SIG_STATE, 8'h00, "reset_state");
    expect_at(3, SIG_RISE,  8'h00, "reset_rise");
    expect_at(3, SIG_FALL,  8'h00, "reset_fall");
    expect_at(3, SIG_LEDS,  8'h00, "reset_leds");
    expect_at(3, SIG_TICK,  8'h00, "reset_tick");
    wait_to(3);
    rst = 1'b0;
    $display("[TB] xor chain blink");
    expect_at(18, SIG_TICK, 8'h00, "blink_tick_pre");
    expect_at(19, SIG_LEDS, 8'h00, "blink_leds_pre");
    expect_at(19, SIG_TICK, 8'h01, "blink_tick_1");
    expect_at(20, SIG_LEDS, 8'hFF, "blink_leds_on");
    expect_at(20, SIG_TICK, 8'h00, "blink_tick_post");
    expect_at(35, SIG_LEDS, 8'hFF, "blink_leds_hold");
    expect_at(35, SIG_TICK, 8'h01, "blink_tick_2");
    expect_at(36, SIG_LEDS, 8'h00, "blink_leds_off");

    wait_to(40);
    $display("[TB] mirror debounce latency");
    applyStimulus(8'h05, 2'd1);
    expect_at(45, SIG_STATE, 8'h00, "mirror_state_early");
    expect_at(46, SIG_STATE, 8'h05, "mirror_state");
    expect_at(46, SIG_RISE,  8'h05, "mirror_rise");
    expect_at(46, SIG_LEDS,  8'h00, "mirror_leds_early");
    expect_at(47, SIG_RISE,  8'h00, "mirror_rise_end");
    expect_at(47, SIG_LEDS,  8'h05, "mirror_leds");

    wait_to(50);
    $display("[TB] three-cycle glitch");
    applyStimulus(8'h0D, 2'd1);
    expect_at(56, SIG_STATE, 8'h05, "glitch_state_a");
    expect_at(56, SIG_RISE,  8'h00, "glitch_rise_a");
    expect_at(57, SIG_LEDS,  8'h05, "glitch_leds_a");
    expect_at(58, SIG_STATE, 8'h05, "glitch_state_b");
    expect_at(58, SIG_RISE,  8'h00, "glitch_rise_b");
    expect_at(59, SIG_LEDS,  8'h05, "glitch_leds_b");
    wait_to(53);
    applyStimulus(8'h05, 2'd1);

    wait_to(60);
    applyStimulus(8'h00, 2'd1);
    expect_at(66, SIG_STATE, 8'h00, "clear_state");
    expect_at(67, SIG_LEDS,  8'h00, "clear_leds");

    wait_to(70);
    $display("[TB] toggle mode");
    applyStimulus(8'h04, 2'd2);
    expect_at(76,  SIG_LEDS, 8'h00, "toggle_leds_pre");
    expect_at(77,  SIG_LEDS, 8'h04, "toggle_leds_on");
    expect_at(86,  SIG_FALL, 8'h04, "toggle_fall_1");
    expect_at(87,  SIG_FALL, 8'h00, "toggle_fall_1_end");
    expect_at(87,  SIG_LEDS, 8'h04, "toggle_leds_hold");
    expect_at(96,  SIG_LEDS, 8'h04, "toggle_leds_hold2");
    expect_at(96,  SIG_RISE, 8'h04, "toggle_rise_2");
    expect_at(97,  SIG_LEDS, 8'h00, "toggle_leds_off");
    expect_at(106, SIG_FALL, 8'h04, "toggle_fall_2");
    wait_to(80);
    applyStimulus(8'h00, 2'd2);
    wait_to(90);
    applyStimulus(8'h04, 2'd2);
    wait_to(100);
    applyStimulus(8'h00, 2'd2);

    wait_to(110);
    $display("[TB] rotate mode");
    applyStimulus(8'h01, 2'd3);
    expect_at(116, SIG_LEDS, 8'h00, "rot_pre");
    expect_at(117, SIG_LEDS, 8'h01, "rot_load");
    expect_at(131, SIG_LEDS, 8'h01, "rot_hold");
    expect_at(132, SIG_LEDS, 8'h02, "rot_1");
    expect_at(148, SIG_LEDS, 8'h04, "rot_2");
    expect_at(164, SIG_LEDS, 8'h08, "rot_3");
    expect_at(180, SIG_LEDS, 8'h10, "rot_4");
    expect_at(196, SIG_LEDS, 8'h20, "rot_5");
    expect_at(212, SIG_LEDS, 8'h40, "rot_6");
    expect_at(228, SIG_LEDS, 8'h80, "rot_7");
    expect_at(244, SIG_LEDS, 8'h01, "rot_wrap");
    wait_to(253);
    applyStimulus(8'h11, 2'd3);
    expect_at(259, SIG_RISE, 8'h10, "rot_rise4");
    expect_at(259, SIG_LEDS, 8'h01, "rot_pre_merge");
    expect_at(260, SIG_LEDS, 8'h12, "rot_merge");

    wait_to(270);
    $display("[TB] mode switch and mid-debounce reset");
    applyStimulus(8'h0F, 2'd1);
    expect_at(276, SIG_STATE, 8'h0F, "sw_state");
    expect_at(276, SIG_RISE,  8'h0E, "sw_rise");
    expect_at(276, SIG_FALL,  8'h10, "sw_fall");
    expect_at(277, SIG_LEDS,  8'h0F, "sw_leds_mirror");
    expect_at(281, SIG_LEDS,  8'h0F, "sw_leds_switch");
    expect_at(282, SIG_LEDS,  8'h0F, "sw_leds_toggle");
    expect_at(287, SIG_LEDS,  8'h0F, "sw_leds_pre_rst");
    expect_at(288, SIG_STATE, 8'h00, "rst2_state");
    expect_at(288, SIG_RISE,  8'h00, "rst2_rise");
    expect_at(288, SIG_FALL,  8'h00, "rst2_fall");
    expect_at(288, SIG_LEDS,  8'h00, "rst2_leds");
    expect_at(288, SIG_TICK,  8'h00, "rst2_tick");
    expect_at(293, SIG_STATE, 8'h00, "redeb_state_early");
    expect_at(294, SIG_STATE, 8'hF0, "redeb_state");
    expect_at(294, SIG_RISE,  8'hF0, "redeb_rise");
    expect_at(294, SIG_LEDS,  8'h00, "redeb_leds_early");
    expect_at(295, SIG_LEDS,  8'hF0, "redeb_leds");
    expect_at(295, SIG_RISE,  8'h00, "redeb_rise_end");
    expect_at(303, SIG_TICK,  8'h00, "redeb_tick_pre");
    expect_at(304, SIG_TICK,  8'h01, "redeb_tick");
    wait_to(280);
    applyStimulus(8'h0F, 2'd2);
    wait_to(285);
    applyStimulus(8'hF0, 2'd2);
    wait_to(287);
    rst = 1'b1;
    wait_to(288);
    rst = 1'b0;

    wait_to(310);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fake_board_io.md
Name: fake_board_io

Overview:
- Clocked, parametrised successor to the simulated board I/O glue.
- Sits between the host-driven simulated board pins (buttons in, LEDs out) and user logic.
- Synchronises and debounces NUM_CH button channels, and produces one-cycle rise/fall pulses.
- Drives NUM_CH LEDs from a selectable pattern generator: XOR chain, mirror, toggle or rotate.

Parameters:
- NUM_CH, 8, number of button/LED channels (>=2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a new level must persist before it is accepted (>=1).
- BLINK_DIV, 16, clock cycles per blink tick (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- buttons  input  NUM_CH  raw button levels from host; asynchronous to clk.
- mode  input  2  LED pattern select: 0=xor chain, 1=mirror, 2=toggle, 3=rotate.
- btn_state  output  NUM_CH  debounced button levels.
- btn_rise  output  NUM_CH  one-cycle pulse when btn_state bit goes 0->1.
- btn_fall  output  NUM_CH  one-cycle pulse when btn_state bit goes 1->0.
- leds  output  NUM_CH  registered LED drive.
- tick  output  1  one-cycle pulse each BLINK_DIV cycles.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: every register clears to 0. This includes both sync stages, debounce counters, btn_state, btn_rise, btn_fall, blink counter, blink bit, tick, pattern register pat, the previous-mode register and leds.
- Sync: two flops per channel, sync1 <= buttons and sync2 <= sync1.
- Debounce, per channel, with counter width clog2(DEBOUNCE_CYCLES)+1:
  - If sync2 == btn_state: count <= 0.
  - Else if count == DEBOUNCE_CYCLES-1: btn_state <= sync2 and count <= 0.
  - Else: count <= count+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 is discarded.
- Latency: if a new level is first sampled into sync1 at edge k and held, btn_state changes at edge k+DEBOUNCE_CYCLES+1.
- Edges: btn_rise and btn_fall are registered in the same edge as the btn_state update and are high for exactly one cycle.
- Blink:
  - Counter runs 0..BLINK_DIV-1 and wraps to 0.
  - tick=1 for the cycle following the wrap edge.
  - Blink bit toggles on each wrap.
- LED next value L, with leds <= L every cycle:
  - mode 0: L[0]=blink; L[i]=L[i-1] ^ btn_state[i] for i>=1 (btn_state[0] unused).
  - mode 1: L=btn_state.
  - mode 2: pat <= pat ^ btn_rise; L=pat_next.
  - mode 3: pat_next = (tick ? rotl(pat,1) : pat) | btn_rise. The rotate is applied first and the rise bits are ORed in afterwards, in the same cycle. pat <= pat_next; L=pat_next.
- LED latency: one edge after the btn_state/btn_rise change, and one edge after the blink toggle.
- pat is updated only in modes 2/3 and holds in modes 0/1.
- Mode change: when mode differs from the registered previous mode, pat <= current leds and L=current leds for that cycle. This avoids a glitch; the new mode takes effect next cycle.
- Reset mid-operation clears everything within one edge. Held buttons then re-debounce from 0: a held button yields btn_rise after DEBOUNCE_CYCLES+2 edges post-reset.
- Simultaneous rise on multiple channels: all bits are handled in parallel.
- Simultaneous rise and fall on the same channel is impossible by construction.

Test Plan:
- Reset, then buttons=8'h00 and mode=0 -> all outputs 0 during reset. After reset, leds alternates 8'h00 / 8'hFF, with transitions every 16 cycles (blink alone propagates down the chain); tick pulses every 16 cycles.
- mode=1, drive buttons=8'h05 at edge k and hold -> btn_state=8'h05 and btn_rise=8'h05 for one cycle at edge k+5. leds=8'h05 at k+6.
- mode=1, pulse buttons[3] high for 3 cycles -> btn_state, btn_rise and leds stay 0.
- mode=2 from leds=0: press and release button 2 twice (each level held 10 cycles) -> leds goes 8'h04, then 8'h00. btn_fall[2] pulses twice.
- mode=3: press button 0 -> leds=8'h01, then rotates left one bit per tick (8'h02, 8'h04, …, 8'h80, 8'h01). Button 4 rise coincident with a tick while pat=8'h01 -> leds=8'h12.
- mode 1->2 with btn_state=8'h0F, then assert rst mid-debounce of a new level -> leds holds 8'h0F across the mode switch. Reset clears all outputs next edge; the held level then re-debounces after 6 edges.
